// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared RV32I decode definitions. Holds the datapath widths,
//                the base-ISA major opcodes, the immediate FORMAT enum and an
//                opcode classifier that reports the immediate format, which
//                source registers are read, whether rd is written and
//                whether the opcode is unsupported.
//  Revision    : 1.0  initial release
// ============================================================================
package rv32_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Immediate layout. FMT_R means "no immediate" and yields zero, which is
    // also what an illegal opcode must carry.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        fmt_e fmt;
        logic use_rs1;
        logic use_rs2;
        logic writes_rd;
        logic illegal;
    } dec_info_t;

    function automatic dec_info_t decode_opcode(input logic [6:0] opcode);
        dec_info_t d;
        d.fmt       = FMT_R;
        d.use_rs1   = 1'b0;
        d.use_rs2   = 1'b0;
        d.writes_rd = 1'b0;
        d.illegal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                d.fmt = FMT_R; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                d.fmt = FMT_B; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
            end
            OPC_STORE: begin
                d.fmt = FMT_S; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                d.fmt = FMT_I; d.use_rs1 = 1'b1; d.writes_rd = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                d.fmt = FMT_U; d.writes_rd = 1'b1;
            end
            OPC_JAL: begin
                d.fmt = FMT_J; d.writes_rd = 1'b1;
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen
//  Description : Combinational RV32I immediate generator. All immediates are
//                sign-extended from instr[31]; FMT_R produces zero.
//  Ports       : instr [31:7] in  - instruction word (opcode bits carry no
//                                   immediate data and are not needed)
//                fmt          in  - immediate format
//                imm   [31:0] out - sign-extended immediate
//  Revision    : 1.0  initial release
// ============================================================================
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:7] instr,
    input  fmt_e        fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'd0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : RV32I instruction decode stage. Captures one instruction from
//                fetch, reads its sources from register_file once no pending
//                write is outstanding on them, and hands a decoded bundle to
//                execute. A per-register scoreboard tracks in-flight writes.
//  Ports       : clk, rst_n                 clock, async active-low reset
//                if_valid/if_ready/if_instr/if_pc   fetch handshake
//                flush                      abort the locally held instruction
//                rf_r1/rf_r2/rf_r_en        register_file read request
//                rf_r1_data/rf_r2_data      register_file read data
//                wb_valid/wb_rd             writeback retire (clears scoreboard)
//                ex_valid/ex_ready          execute handshake
//                ex_pc/ex_rs1_data/ex_rs2_data/ex_imm/ex_rd/ex_opcode/
//                ex_funct3/ex_funct7b5/ex_illegal   decoded bundle
//  Revision    : 1.0  initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN  = rv32_pkg::XLEN,
    parameter int NREGS = rv32_pkg::NREGS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic [4:0]      rf_r1,
    output logic [4:0]      rf_r2,
    output logic            rf_r_en,
    input  logic [XLEN-1:0] rf_r1_data,
    input  logic [XLEN-1:0] rf_r2_data,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_illegal
);

    import rv32_pkg::*;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_OUT    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [NREGS-1:0]  sb_q, sb_d;
    logic              ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]   ex_pc_q, ex_pc_d;
    logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic [6:0]        ex_opcode_q, ex_opcode_d;
    logic [2:0]        ex_funct3_q, ex_funct3_d;
    logic              ex_funct7b5_q, ex_funct7b5_d;
    logic              ex_illegal_q, ex_illegal_d;

    dec_info_t         dec;
    logic [31:0]       imm;
    logic [4:0]        rs1, rs2, rd;
    logic              hazard;
    logic [NREGS-1:0]  sb_set, sb_clr;

    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];
    assign rd  = instr_q[11:7];
    assign dec = decode_opcode(instr_q[6:0]);

    imm_gen u_imm_gen (
        .instr (instr_q[31:7]),
        .fmt   (dec.fmt),
        .imm   (imm)
    );

    // Hazard looks only at the registered scoreboard, so a writeback clear
    // lets the read go out one cycle later, once register_file holds the
    // freshly written value.
    assign hazard = (dec.use_rs1 && (rs1 != 5'd0) && sb_q[rs1]) ||
                    (dec.use_rs2 && (rs2 != 5'd0) && sb_q[rs2]);

    assign rf_r1    = rs1;
    assign rf_r2    = rs2;
    assign rf_r_en  = (state_q == ST_DECODE) && !hazard && !flush;
    assign if_ready = (state_q == ST_IDLE);

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_imm_d      = ex_imm_q;
        ex_rd_d       = ex_rd_q;
        ex_opcode_d   = ex_opcode_q;
        ex_funct3_d   = ex_funct3_q;
        ex_funct7b5_d = ex_funct7b5_q;
        ex_illegal_d  = ex_illegal_q;
        sb_set        = '0;
        sb_clr        = '0;

        if (wb_valid && (wb_rd != 5'd0)) begin
            sb_clr[wb_rd] = 1'b1;
        end

        if (flush) begin
            state_d    = ST_IDLE;
            ex_valid_d = 1'b0;
            // The held bundle will never retire, so release the register it
            // reserved on its way into OUT.
            if ((state_q == ST_OUT) && (ex_rd_q != 5'd0)) begin
                sb_clr[ex_rd_q] = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (if_valid) begin
                        instr_d = if_instr;
                        pc_d    = if_pc;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!hazard) begin
                        if (dec.writes_rd && (rd != 5'd0)) begin
                            sb_set[rd] = 1'b1;
                        end
                        ex_valid_d    = 1'b1;
                        ex_pc_d       = pc_q;
                        ex_imm_d      = imm;
                        ex_rd_d       = dec.writes_rd ? rd : 5'd0;
                        ex_opcode_d   = instr_q[6:0];
                        ex_funct3_d   = instr_q[14:12];
                        ex_funct7b5_d = instr_q[30];
                        ex_illegal_d  = dec.illegal;
                        state_d       = ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (ex_ready) begin
                        ex_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Set after clear: a new reservation outranks a same-edge retire.
        sb_d = (sb_q & ~sb_clr) | sb_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            instr_q       <= 32'd0;
            pc_q          <= '0;
            sb_q          <= '0;
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= 5'd0;
            ex_opcode_q   <= 7'd0;
            ex_funct3_q   <= 3'd0;
            ex_funct7b5_q <= 1'b0;
            ex_illegal_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            sb_q          <= sb_d;
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_imm_q      <= ex_imm_d;
            ex_rd_q       <= ex_rd_d;
            ex_opcode_q   <= ex_opcode_d;
            ex_funct3_q   <= ex_funct3_d;
            ex_funct7b5_q <= ex_funct7b5_d;
            ex_illegal_q  <= ex_illegal_d;
        end
    end

    // register_file keeps its last read data while rf_r_en is low, so the
    // source operands are forwarded rather than captured here.
    assign ex_rs1_data = rf_r1_data;
    assign ex_rs2_data = rf_r2_data;

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rd       = ex_rd_q;
    assign ex_opcode   = ex_opcode_q;
    assign ex_funct3   = ex_funct3_q;
    assign ex_funct7b5 = ex_funct7b5_q;
    assign ex_illegal  = ex_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Directed self-checking bench for decode_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    localparam logic [31:0] I_ADDI_X5 = 32'h0050_0293; // addi x5,x0,5
    localparam logic [31:0] I_ADD_X7  = 32'h0062_83B3; // add  x7,x5,x6
    localparam logic [31:0] I_SW      = 32'hFE51_2E23; // sw   x5,-4(x2)
    localparam logic [31:0] I_ADD_X28 = 32'h000E_00B3; // add  x1,x28,x0
    localparam logic [31:0] I_ILLEGAL = 32'hFFFF_FFFF;
    localparam logic [31:0] RD1       = 32'hA5A5_0001;
    localparam logic [31:0] RD2       = 32'h5A5A_0002;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic [4:0]  rf_r1, rf_r2;
    logic        rf_r_en;
    logic [31:0] rf_r1_data, rf_r2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .flush       (flush),
        .rf_r1       (rf_r1),
        .rf_r2       (rf_r2),
        .rf_r_en     (rf_r_en),
        .rf_r1_data  (rf_r1_data),
        .rf_r2_data  (rf_r2_data),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_pc       (ex_pc),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .ex_rd       (ex_rd),
        .ex_opcode   (ex_opcode),
        .ex_funct3   (ex_funct3),
        .ex_funct7b5 (ex_funct7b5),
        .ex_illegal  (ex_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one edge; the stage is IDLE beforehand.
    task automatic accept(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        tick();
        if_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; ex_ready = 1'b1;
        rf_r1_data = RD1; rf_r2_data = RD2;
        tick(); tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0b want 0", ex_valid); end
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready: got %0b want 1", if_ready); end
        checks++; if (rf_r_en !== 1'b0) begin errors++; $display("FAIL reset_rf_r_en: got %0b want 0", rf_r_en); end
        checks++; if ({ex_rd, ex_imm, ex_pc} !== '0) begin errors++; $display("FAIL reset_bundle: rd=%0d imm=%h pc=%h want 0", ex_rd, ex_imm, ex_pc); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        ex_ready = 1'b1;
        accept(I_ADDI_X5, 32'h0000_0100);
        checks++; if (rf_r_en !== 1'b1) begin errors++; $display("FAIL addi_rf_r_en: got %0b want 1", rf_r_en); end
        checks++; if (rf_r1 !== 5'd0) begin errors++; $display("FAIL addi_rf_r1: got %0d want 0", rf_r1); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL addi_early_valid: got %0b want 0", ex_valid); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL addi_if_ready: got %0b want 0", if_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %0b want 1", ex_valid); end
        checks++; if (rf_r_en !== 1'b0) begin errors++; $display("FAIL addi_rf_r_en_out: got %0b want 0", rf_r_en); end
        checks++; if (ex_imm !== 32'd5) begin errors++; $display("FAIL addi_imm: got %h want 00000005", ex_imm); end
        checks++; if (ex_rd !== 5'd5) begin errors++; $display("FAIL addi_rd: got %0d want 5", ex_rd); end
        checks++; if (ex_opcode !== 7'b0010011) begin errors++; $display("FAIL addi_opcode: got %b want 0010011", ex_opcode); end
        checks++; if (ex_pc !== 32'h0000_0100) begin errors++; $display("FAIL addi_pc: got %h want 00000100", ex_pc); end
        checks++; if (ex_rs1_data !== RD1) begin errors++; $display("FAIL addi_rs1_data: got %h want %h", ex_rs1_data, RD1); end
        checks++; if ({ex_illegal, ex_funct3} !== 4'd0) begin errors++; $display("FAIL addi_flags: ill=%0b f3=%0d want 0", ex_illegal, ex_funct3); end
        tick();
        checks++; if (ex_valid !== 1'b0 || if_ready !== 1'b1) begin errors++; $display("FAIL addi_retire: valid=%0b ready=%0b want 0/1", ex_valid, if_ready); end
    endtask

    task automatic test_raw_stall();
        ex_ready = 1'b1;
        accept(I_ADD_X7, 32'h0000_0104);
        checks++; if (rf_r_en !== 1'b0) begin errors++; $display("FAIL raw_stall_en: got %0b want 0", rf_r_en); end
        checks++; if (rf_r1 !== 5'd5 || rf_r2 !== 5'd6) begin errors++; $display("FAIL raw_addr: got r1=%0d r2=%0d want 5/6", rf_r1, rf_r2); end
        tick(); tick();
        checks++; if (rf_r_en !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL raw_still_stalled: en=%0b valid=%0b want 0/0", rf_r_en, ex_valid); end
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1;
        checks++; if (rf_r_en !== 1'b0) begin errors++; $display("FAIL raw_same_cycle_read: got %0b want 0", rf_r_en); end
        tick();
        wb_valid = 1'b0; wb_rd = 5'd0;
        #1;
        checks++; if (rf_r_en !== 1'b1 || rf_r1 !== 5'd5 || rf_r2 !== 5'd6) begin errors++; $display("FAIL raw_release: en=%0b r1=%0d r2=%0d want 1/5/6", rf_r_en, rf_r1, rf_r2); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_imm !== 32'd0) begin errors++; $display("FAIL raw_bundle: valid=%0b rd=%0d imm=%h want 1/7/0", ex_valid, ex_rd, ex_imm); end
        checks++; if (ex_opcode !== 7'b0110011) begin errors++; $display("FAIL raw_opcode: got %b want 0110011", ex_opcode); end
        tick();
    endtask

    task automatic test_store_backpressure();
        ex_ready = 1'b0;
        accept(I_SW, 32'h0000_0200);
        checks++; if (rf_r_en !== 1'b1) begin errors++; $display("FAIL sw_rf_r_en: got %0b want 1", rf_r_en); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ex_valid !== 1'b1 || ex_imm !== 32'hFFFF_FFFC || ex_rd !== 5'd0 || ex_funct3 !== 3'b010 ||
                ex_funct7b5 !== 1'b1 || ex_pc !== 32'h0000_0200 || rf_r_en !== 1'b0) begin
                errors++;
                $display("FAIL sw_hold[%0d]: valid=%0b imm=%h rd=%0d f3=%0d f7b5=%0b pc=%h en=%0b want 1/fffffffc/0/2/1/00000200/0",
                         i, ex_valid, ex_imm, ex_rd, ex_funct3, ex_funct7b5, ex_pc, rf_r_en);
            end
            tick();
        end
        ex_ready = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL sw_retire: got %0b want 0", ex_valid); end
        // The store's rd field (x28) must not have been reserved.
        accept(I_ADD_X28, 32'h0000_0204);
        checks++; if (rf_r_en !== 1'b1) begin errors++; $display("FAIL sw_no_sb_set: got %0b want 1", rf_r_en); end
        tick(); tick();
    endtask

    task automatic test_illegal();
        ex_ready = 1'b1;
        accept(I_ILLEGAL, 32'h0000_0300);
        checks++; if (rf_r_en !== 1'b1) begin errors++; $display("FAIL ill_no_stall: got %0b want 1", rf_r_en); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag: valid=%0b ill=%0b want 1/1", ex_valid, ex_illegal); end
        checks++; if (ex_imm !== 32'd0 || ex_rd !== 5'd0) begin errors++; $display("FAIL ill_fields: imm=%h rd=%0d want 0/0", ex_imm, ex_rd); end
        checks++; if (ex_opcode !== 7'h7F) begin errors++; $display("FAIL ill_opcode: got %h want 7f", ex_opcode); end
        tick();
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        accept(I_ADDI_X5, 32'h0000_0400);
        tick();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %0b want 1", ex_valid); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0 || if_ready !== 1'b1) begin errors++; $display("FAIL flush_out: valid=%0b ready=%0b want 0/1", ex_valid, if_ready); end
        // x5 released by the flush, so add x7,x5,x6 reads at once.
        accept(I_ADD_X7, 32'h0000_0404);
        checks++; if (rf_r_en !== 1'b1) begin errors++; $display("FAIL flush_sb_clear: got %0b want 1", rf_r_en); end
        ex_ready = 1'b1;
        tick(); tick();
        // x7 now reserved: add x7,x5,x6 again? use a reader of x7 to stall, then flush in DECODE.
        accept(32'h0003_8413, 32'h0000_0408); // addi x8,x7,0
        checks++; if (rf_r_en !== 1'b0) begin errors++; $display("FAIL flush_dec_stall: got %0b want 0", rf_r_en); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++; if (if_ready !== 1'b1 || ex_valid !== 1'b0) begin errors++; $display("FAIL flush_decode: ready=%0b valid=%0b want 1/0", if_ready, ex_valid); end
    endtask

    task automatic test_reset_mid();
        ex_ready = 1'b0;
        accept(I_ADDI_X5, 32'h0000_0500);
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0 || if_ready !== 1'b1) begin errors++; $display("FAIL rst_mid: valid=%0b ready=%0b want 0/1", ex_valid, if_ready); end
        checks++; if (ex_rd !== 5'd0 || ex_imm !== 32'd0) begin errors++; $display("FAIL rst_mid_bundle: rd=%0d imm=%h want 0/0", ex_rd, ex_imm); end
        tick();
        rst_n = 1'b1;
        tick();
        ex_ready = 1'b1;
        // Scoreboard cleared by reset: x5 and x7 both free.
        accept(I_ADD_X7, 32'h0000_0504);
        checks++; if (rf_r_en !== 1'b1) begin errors++; $display("FAIL rst_sb_clear: got %0b want 1", rf_r_en); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_pc !== 32'h0000_0504) begin errors++; $display("FAIL rst_first_accept: valid=%0b rd=%0d pc=%h want 1/7/00000504", ex_valid, ex_rd, ex_pc); end
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_raw_stall();
        test_store_backpressure();
        test_illegal();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
